controle_irrigacao: RTL and testbench
=====================================

Name: controle_irrigacao

Overview:
- Sequential controller directly downstream of the tank level decoder.
- Consumes the decoded level flags (Cheio/Medio/Baixo/Vazio/Erro), filters them, and drives the inlet valve and the irrigation pump.
- Uses a fill/irrigate state machine with timeouts and a latched fault state that requires operator acknowledge.
- Replaces the decoder's purely combinational valve equation with hysteresis: fill from Baixo/Vazio up to Cheio.

Parameters:
- DEB_CYCLES, 4: consecutive identical samples required before a level vector is accepted (≥1).
- FILL_TIMEOUT, 1000: maximum cycles in ENCHENDO without an accepted level change.
- IRR_CYCLES, 500: maximum length of one irrigation run, in cycles.
- CNT_W, 16: width of the internal counters; must hold FILL_TIMEOUT and IRR_CYCLES.

Ports:
- clk  input  1  system clock; one clock domain, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- Cheio  input  1  level decoder: tank full.
- Medio  input  1  level decoder: tank medium.
- Baixo  input  1  level decoder: tank low.
- Vazio  input  1  level decoder: tank empty.
- Erro  input  1  level decoder: inconsistent sensor combination.
- Seco  input  1  soil-dry request; irrigation wanted while high.
- Ack  input  1  operator acknowledge; single-cycle pulse clears FALHA.
- ValvulaEntrada  output  1  inlet valve open.
- Bomba  output  1  irrigation pump on.
- Falha  output  1  controller in FALHA.
- Alarme  output  1  Falha OR accepted level Baixo/Vazio/Erro.
- Estado  output  2  state code: 0=REPOUSO, 1=ENCHENDO, 2=IRRIGANDO, 3=FALHA.

Behaviour:
- Reset (synchronous):
  - State = REPOUSO.
  - Accepted vector = all zero; NivelOk = 0.
  - Counters = 0.
  - All outputs 0.
- Filter: raw vector {Cheio,Medio,Baixo,Vazio,Erro}.
  - The accepted vector updates once the raw vector has been sampled identical on DEB_CYCLES consecutive edges.
  - Raw held constant from edge k is therefore accepted at edge k+DEB_CYCLES-1.
  - Any change restarts the count.
  - First acceptance sets internal NivelOk = 1.
  - The FSM ignores levels while NivelOk = 0.
- Outputs decode combinationally from the state register and accepted vector:
  - ValvulaEntrada = (ENCHENDO).
  - Bomba = (IRRIGANDO).
  - Falha = (FALHA).
  - Estado = state code.
- FSM: evaluated each edge with NivelOk = 1, using the accepted vector only. Listed in priority order within each state.
  - Any state except FALHA: accepted Erro = 1 -> FALHA.
  - REPOUSO:
    - Baixo or Vazio -> ENCHENDO.
    - Otherwise, Seco AND (Medio or Cheio) -> IRRIGANDO.
    - Otherwise stay.
  - ENCHENDO:
    - Cheio -> REPOUSO.
    - Fill counter reaches FILL_TIMEOUT -> FALHA.
    - Fill counter clears on entry and on every accepted-vector change; otherwise increments by 1 per cycle.
    - Medio is not an exit (hysteresis).
  - IRRIGANDO:
    - Baixo or Vazio -> ENCHENDO (dry-run protection; pump off the same edge the valve opens).
    - Seco = 0 -> REPOUSO.
    - Run counter reaches IRR_CYCLES-1 -> REPOUSO.
    - Run counter clears on entry and increments each cycle in IRRIGANDO.
  - FALHA:
    - Outputs off except Falha and Alarme.
    - Exits to REPOUSO only when Ack = 1 AND accepted Erro = 0 on the same edge.
    - Ack in any other state is ignored.
- Boundary rules:
  - Bomba and ValvulaEntrada are never 1 in the same cycle.
  - Counters saturate and never wrap.
  - Seco toggling inside ENCHENDO has no effect.
  - Reset asserted mid-fill or mid-irrigation returns to REPOUSO and closes valve and pump on that edge.
  - After reset, refiltering (DEB_CYCLES samples) precedes any action.
  - Raw inputs changing faster than DEB_CYCLES never alter the accepted vector.

Test Plan (DEB_CYCLES=4, FILL_TIMEOUT=20, IRR_CYCLES=10):
- Reset, then hold Vazio=1 -> Estado=1 and ValvulaEntrada=1 on the edge after acceptance. Step to Baixo, then Medio (valve stays 1), then Cheio -> Estado=0, valve=0.
- Hold Medio, Seco=1 -> Bomba=1 for exactly 10 cycles, then Estado=0. Drop Seco after 3 cycles in a repeat run -> Bomba=0 next edge.
- During IRRIGANDO force Baixo -> after filter delay Estado=1, Bomba=0, ValvulaEntrada=1 on the same edge.
- Hold Baixo with no change for 20 cycles in ENCHENDO -> Estado=3, Falha=1, Alarme=1, valve=0.
  - Ack while Erro accepted -> stays 3.
  - Ack with Erro=0 -> Estado=0.
- Toggle Erro 1/0 every 2 cycles -> no transition. Hold Erro for 4 cycles -> FALHA.
- Assert reset mid-fill -> valve=0, Estado=0 same edge. With Vazio held, no refill until 4 cycles after reset release.

Source files
------------

// File: rtl/controle_irrigacao.sv
// Purpose : level-flag filter plus fill/irrigate controller driving inlet valve and pump.
// Latency : a raw level vector stable for DEB_CYCLES edges is accepted; the FSM acts on it one edge later.
// Backpres: none; inputs are sampled every clock, outputs decode combinationally from registers.
// Ports   : clk/reset (sync, active-high); Cheio/Medio/Baixo/Vazio/Erro level flags from the decoder;
//           Seco irrigation request; Ack fault acknowledge; ValvulaEntrada/Bomba actuators;
//           Falha fault flag; Alarme fault-or-low-level flag; Estado 2-bit state code.
module controle_irrigacao #(
   parameter int DEB_CYCLES   = 4,
   parameter int FILL_TIMEOUT = 1000,
   parameter int IRR_CYCLES   = 500,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Cheio,
   input  logic       Medio,
   input  logic       Baixo,
   input  logic       Vazio,
   input  logic       Erro,
   input  logic       Seco,
   input  logic       Ack,
   output logic       ValvulaEntrada,
   output logic       Bomba,
   output logic       Falha,
   output logic       Alarme,
   output logic [1:0] Estado
);

   typedef enum logic [1:0] {
      REPOUSO   = 2'd0,
      ENCHENDO  = 2'd1,
      IRRIGANDO = 2'd2,
      FALHA     = 2'd3
   } estado_t;

   localparam int DW = $clog2(DEB_CYCLES + 1);

   estado_t          estado, estado_prox;
   logic [4:0]       bruto, amostra, aceito;
   logic [DW-1:0]    deb_cnt, deb_prox;
   logic             nivel_ok, aceita, muda;
   logic [CNT_W-1:0] cnt_ench, cnt_irr;
   logic             a_cheio, a_medio, a_baixo, a_vazio, a_erro;

   assign bruto = {Cheio, Medio, Baixo, Vazio, Erro};

   // deb_cnt holds how many consecutive identical samples ended at the last edge;
   // zero means no valid previous sample (just out of reset). It stops at DEB_CYCLES.
   always_comb begin
      deb_prox = DW'(1);
      if (deb_cnt != '0 && bruto == amostra) begin
         if (deb_cnt == DW'(DEB_CYCLES))
            deb_prox = deb_cnt;
         else
            deb_prox = deb_cnt + DW'(1);
      end
   end

   assign aceita = (deb_prox == DW'(DEB_CYCLES));
   assign muda   = aceita && (bruto != aceito);

   always_ff @(posedge clk) begin
      if (reset) begin
         amostra  <= '0;
         deb_cnt  <= '0;
         aceito   <= '0;
         nivel_ok <= 1'b0;
      end else begin
         amostra <= bruto;
         deb_cnt <= deb_prox;
         if (aceita) begin
            aceito   <= bruto;
            nivel_ok <= 1'b1;
         end
      end
   end

   assign {a_cheio, a_medio, a_baixo, a_vazio, a_erro} = aceito;

   always_comb begin
      estado_prox = estado;
      if (nivel_ok) begin
         if (estado != FALHA && a_erro) begin
            estado_prox = FALHA;
         end else begin
            case (estado)
               REPOUSO: begin
                  if (a_baixo || a_vazio)
                     estado_prox = ENCHENDO;
                  else if (Seco && (a_medio || a_cheio))
                     estado_prox = IRRIGANDO;
               end
               ENCHENDO: begin
                  // Medio is deliberately not an exit: fill runs all the way to Cheio.
                  if (a_cheio)
                     estado_prox = REPOUSO;
                  else if (cnt_ench == CNT_W'(FILL_TIMEOUT))
                     estado_prox = FALHA;
               end
               IRRIGANDO: begin
                  // Low level wins over everything so the pump never runs the tank dry.
                  if (a_baixo || a_vazio)
                     estado_prox = ENCHENDO;
                  else if (!Seco)
                     estado_prox = REPOUSO;
                  else if (cnt_irr == CNT_W'(IRR_CYCLES - 1))
                     estado_prox = REPOUSO;
               end
               FALHA: begin
                  if (Ack && !a_erro)
                     estado_prox = REPOUSO;
               end
               default: estado_prox = REPOUSO;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= REPOUSO;
         cnt_ench <= '0;
         cnt_irr  <= '0;
      end else begin
         estado <= estado_prox;

         // Fill timeout measures time without level progress, so any accepted change restarts it.
         if (estado_prox != estado || muda)
            cnt_ench <= '0;
         else if (estado == ENCHENDO && cnt_ench != '1)
            cnt_ench <= cnt_ench + CNT_W'(1);

         if (estado_prox != estado)
            cnt_irr <= '0;
         else if (estado == IRRIGANDO && cnt_irr != '1)
            cnt_irr <= cnt_irr + CNT_W'(1);
      end
   end

   assign ValvulaEntrada = (estado == ENCHENDO);
   assign Bomba          = (estado == IRRIGANDO);
   assign Falha          = (estado == FALHA);
   assign Alarme         = Falha || a_baixo || a_vazio || a_erro;
   assign Estado         = estado;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Purpose : directed and random stimulus for controle_irrigacao checked against a timestamp-based model.
// Latency : outputs compared 1 time unit after every rising edge.
// Backpres: none.
module tb_controle_irrigacao;

   localparam int DEB  = 4;
   localparam int FILL = 20;
   localparam int IRR  = 10;

   localparam logic [4:0] NC = 5'b10000;
   localparam logic [4:0] NM = 5'b01000;
   localparam logic [4:0] NB = 5'b00100;
   localparam logic [4:0] NV = 5'b00010;
   localparam logic [4:0] NE = 5'b00001;

   logic       clk = 1'b0;
   logic       reset, Cheio, Medio, Baixo, Vazio, Erro, Seco, Ack;
   logic       ValvulaEntrada, Bomba, Falha, Alarme;
   logic [1:0] Estado;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: state code, accepted vector and event timestamps.
   int         m_st;
   logic [4:0] m_acc;
   bit         m_ok;
   logic [4:0] hist[$];
   int         t, t_enter, t_chg;

   controle_irrigacao #(
      .DEB_CYCLES  (DEB),
      .FILL_TIMEOUT(FILL),
      .IRR_CYCLES  (IRR),
      .CNT_W       (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .Cheio         (Cheio),
      .Medio         (Medio),
      .Baixo         (Baixo),
      .Vazio         (Vazio),
      .Erro          (Erro),
      .Seco          (Seco),
      .Ack           (Ack),
      .ValvulaEntrada(ValvulaEntrada),
      .Bomba         (Bomba),
      .Falha         (Falha),
      .Alarme        (Alarme),
      .Estado        (Estado)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic nivel(input logic [4:0] v);
      {Cheio, Medio, Baixo, Vazio, Erro} = v;
   endtask

   // Advance the model by one rising edge using the inputs the DUT is about to sample.
   task automatic modelo();
      logic [4:0] raw;
      int         ns, base;
      bit         stable;
      raw = {Cheio, Medio, Baixo, Vazio, Erro};
      t++;
      if (reset) begin
         m_st = 0; m_acc = '0; m_ok = 0;
         hist.delete();
         t_enter = t; t_chg = t;
      end else begin
         ns = m_st;
         base = (t_enter > t_chg) ? t_enter : t_chg;
         if (m_ok) begin
            if (m_st != 3 && m_acc[0]) ns = 3;
            else if (m_st == 0) begin
               if (m_acc[2] || m_acc[1]) ns = 1;
               else if (Seco && (m_acc[3] || m_acc[4])) ns = 2;
            end else if (m_st == 1) begin
               if (m_acc[4]) ns = 0;
               else if (t - base == FILL + 1) ns = 3;
            end else if (m_st == 2) begin
               if (m_acc[2] || m_acc[1]) ns = 1;
               else if (!Seco) ns = 0;
               else if (t - t_enter == IRR) ns = 0;
            end else begin
               if (Ack && !m_acc[0]) ns = 0;
            end
         end
         if (ns != m_st) t_enter = t;
         m_st = ns;

         hist.push_back(raw);
         if (hist.size() > DEB) void'(hist.pop_front());
         stable = (hist.size() == DEB);
         foreach (hist[i]) if (hist[i] != raw) stable = 0;
         if (stable) begin
            if (raw != m_acc) t_chg = t;
            m_acc = raw;
            m_ok  = 1;
         end
      end
   endtask

   task automatic compara();
      verifica("estado", Estado, m_st);
      verifica("valvula", ValvulaEntrada, m_st == 1);
      verifica("bomba", Bomba, m_st == 2);
      verifica("falha", Falha, m_st == 3);
      verifica("alarme", Alarme, (m_st == 3) || m_acc[2] || m_acc[1] || m_acc[0]);
      verifica("exclusivo", Bomba & ValvulaEntrada, 0);
   endtask

   task automatic ciclo();
      modelo();
      @(posedge clk);
      #1;
      compara();
   endtask

   initial begin
      int len;
      int k;
      t = 0; t_enter = 0; t_chg = 0;
      m_st = 0; m_acc = '0; m_ok = 0;
      reset = 1'b1; Seco = 1'b0; Ack = 1'b0;
      nivel(5'b0);
      ciclo(); ciclo();
      verifica("rst_estado", Estado, 0);
      verifica("rst_saidas", {ValvulaEntrada, Bomba, Falha, Alarme}, 0);
      reset = 1'b0;

      // Fill from empty through low and medium up to full.
      nivel(NV);
      repeat (DEB) ciclo();
      verifica("filtro_espera", Estado, 0);
      ciclo();
      verifica("enche_estado", Estado, 1);
      verifica("enche_valvula", ValvulaEntrada, 1);
      nivel(NB); repeat (6) ciclo();
      nivel(NM); repeat (6) ciclo();
      verifica("histerese_medio", ValvulaEntrada, 1);
      nivel(NC); repeat (6) ciclo();
      verifica("cheio_estado", Estado, 0);
      verifica("cheio_valvula", ValvulaEntrada, 0);

      // Full irrigation run length.
      nivel(NM); Seco = 1'b1;
      len = 0; k = 0;
      while (!Bomba && k < 20) begin ciclo(); k++; end
      while (Bomba && k < 60) begin len++; ciclo(); k++; end
      verifica("irr_duracao", len, IRR);
      verifica("irr_fim", Estado, 0);
      Seco = 1'b0; ciclo();

      // Dropping Seco mid-run stops the pump on the next edge.
      Seco = 1'b1; ciclo();
      verifica("irr_reinicio", Bomba, 1);
      repeat (3) ciclo();
      Seco = 1'b0; ciclo();
      verifica("seco_corta", Bomba, 0);

      // Low level during irrigation switches pump to valve on the same edge.
      Seco = 1'b1; ciclo(); ciclo();
      nivel(NB);
      repeat (DEB) ciclo();
      verifica("seco_protege_antes", Bomba, 1);
      ciclo();
      verifica("protege_estado", Estado, 1);
      verifica("protege_troca", {Bomba, ValvulaEntrada}, 2'b01);

      // Fill timeout with Seco wiggling (must be ignored).
      repeat (FILL) begin Seco = 1'($urandom_range(0, 1)); ciclo(); end
      verifica("timeout_antes", Estado, 1);
      ciclo();
      verifica("timeout_estado", Estado, 3);
      verifica("timeout_saidas", {ValvulaEntrada, Falha, Alarme}, 3'b011);
      Seco = 1'b0;

      // Ack ignored while Erro is accepted, honoured once it clears.
      nivel(NE); repeat (DEB + 1) ciclo();
      Ack = 1'b1; ciclo(); Ack = 1'b0;
      verifica("ack_com_erro", Estado, 3);
      nivel(NM); repeat (DEB + 1) ciclo();
      Ack = 1'b1; ciclo(); Ack = 1'b0;
      verifica("ack_libera", Estado, 0);

      // Erro chattering faster than the filter never reaches the FSM.
      repeat (5) begin
         nivel(NM | NE); ciclo(); ciclo();
         nivel(NM);      ciclo(); ciclo();
      end
      verifica("erro_oscila", Estado, 0);
      nivel(NM | NE); repeat (DEB + 1) ciclo();
      verifica("erro_mantido", Estado, 3);
      nivel(NM); repeat (DEB + 1) ciclo();
      Ack = 1'b1; ciclo(); Ack = 1'b0;

      // Reset mid-fill closes the valve at once and forces refiltering.
      nivel(NV); repeat (DEB + 3) ciclo();
      verifica("prereset_valvula", ValvulaEntrada, 1);
      reset = 1'b1; ciclo(); reset = 1'b0;
      verifica("reset_valvula", ValvulaEntrada, 0);
      verifica("reset_estado", Estado, 0);
      repeat (DEB) begin ciclo(); verifica("refiltra", Estado, 0); end
      ciclo();
      verifica("refiltra_enche", Estado, 1);

      // Random level sequences, requests, acknowledges and occasional resets.
      for (int i = 0; i < 300; i++) begin
         logic [4:0] v;
         int         r, hold;
         r = $urandom_range(0, 6);
         case (r)
            0: v = NC;
            1: v = NM;
            2: v = NB;
            3: v = NV;
            4: v = NE;
            5: v = NM;
            default: v = 5'($urandom);
         endcase
         nivel(v);
         Seco = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 12);
         for (int j = 0; j < hold; j++) begin
            Ack   = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 249) == 0);
            ciclo();
         end
      end
      reset = 1'b0; Ack = 1'b0;
      ciclo();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
